button_conditioner: RTL

- Front-end input stage that sits directly upstream of the LED controller.
- Takes raw board pushbuttons and produces a clean mode level plus the 2-bit up/down command the controller consumes.
- Per button: 2-flop synchronizer, then a debounce state machine, then edge detect or level decode.
- All outputs are registered and synchronous to i_clk, so downstream logic needs no further synchronization.

---
 rtl/button_conditioner.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Pushbutton front end: 2-flop sync, per-button debounce FSM, mode toggle and up/down decode.
// Define UD_LATCH_EN to latch the up/down direction on press instead of level decoding it.

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic level_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHECK_HIGH,
        STABLE_HIGH,
        CHECK_LOW
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            unique case (state_q)
                STABLE_LOW: begin
                    if (sync_i) begin
                        state_q <= CHECK_HIGH;
                        cnt_q   <= CNT_ONE;
                    end
                end
                CHECK_HIGH: begin
                    // A bounce back low restarts the qualification window.
                    if (!sync_i) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= STABLE_HIGH;
                        level_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_i) begin
                        state_q <= CHECK_LOW;
                        cnt_q   <= CNT_ONE;
                    end
                end
                CHECK_LOW: begin
                    if (sync_i) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= STABLE_LOW;
                        level_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= STABLE_LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = level_q;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    output logic       o_mode,
    output logic       o_mode_pulse,
    output logic [1:0] o_incr_decr
);

    // Button order in the vectors below: [2]=mode, [1]=down, [0]=up.
    logic [2:0] raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] sync_x;
    logic [2:0] deb;
    logic [2:0] deb_prev_q;
    logic [2:0] rise;

    logic       mode_q;
    logic       mode_pulse_q;
    logic [1:0] ud_q;

    assign raw = {i_btn_mode, i_btn_down, i_btn_up};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign sync_x = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;

    for (genvar g = 0; g < 3; g++) begin : g_deb
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (i_clk),
            .rst_ni (i_rst_n),
            .sync_i (sync_x[g]),
            .level_o(deb[g])
        );
    end

    assign rise = deb & ~deb_prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb_prev_q   <= '0;
            mode_q       <= 1'b0;
            mode_pulse_q <= 1'b0;
            ud_q         <= 2'b00;
        end else begin
            deb_prev_q   <= deb;
            mode_pulse_q <= rise[2];
            if (rise[2]) begin
                mode_q <= ~mode_q;
            end
`ifdef UD_LATCH_EN
            // A mode change takes priority and clears any latched direction.
            if (rise[2]) begin
                ud_q <= 2'b00;
            end else if (rise[0] && rise[1]) begin
                ud_q <= 2'b00;
            end else if (rise[0]) begin
                ud_q <= 2'b01;
            end else if (rise[1]) begin
                ud_q <= 2'b10;
            end
`else
            ud_q <= {deb[1] & ~deb[0], deb[0] & ~deb[1]};
`endif
        end
    end

    assign o_mode       = mode_q;
    assign o_mode_pulse = mode_pulse_q;
    assign o_incr_decr  = ud_q;

endmodule
